// File: rtl/muldiv_if.sv
// Request/result bundle between the EX stage and the iterative multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit that owns the architectural HI/LO registers.
// Signed operations run on operand magnitudes; the sign is restored in FIX so the
// datapath only ever performs unsigned shift-add / restoring-divide steps.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   acc_q;      // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]     opnd_q;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic                 is_div_q;
    logic                 neg_q;      // product / quotient must be negated
    logic                 rneg_q;     // remainder must be negated (dividend was negative)
    logic                 div0_q;
    logic                 done_q;

    // Request decode
    logic             is_muldiv, is_mthi, is_mtlo, signed_op;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic             last_step;

    assign is_muldiv = ~bus.op[2];
    assign is_mthi   = (bus.op == 3'b100);
    assign is_mtlo   = (bus.op == 3'b101);
    assign signed_op = ~bus.op[0];
    assign a_neg     = signed_op & bus.a[WIDTH-1];
    assign b_neg     = signed_op & bus.b[WIDTH-1];
    assign a_abs     = a_neg ? -bus.a : bus.a;
    assign b_abs     = b_neg ? -bus.b : bus.b;
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

    // State register
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values,
    // independent of the order the always_ff blocks are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides everything, including a same-cycle start
    // NOTE: state_d gets a default before any branch, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.start && is_muldiv) state_d = CALC;
                CALC:    if (last_step) state_d = FIX;
                FIX:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // One radix-2 iteration: shift-add multiply or restoring divide
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] acc_step;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd_q};
        if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
                acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    // Sign restoration and divide-by-zero override for the FIX write-back.
    // Most-negative / -1 needs no special case: the magnitude quotient is
    // 2^(WIDTH-1) and negating it yields the most-negative value again.
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem, res_hi, res_lo;

    always_comb begin
        prod = neg_q  ? -acc_q : acc_q;
        quot = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        if (!is_div_q) begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (div0_q) begin
            res_hi = '0;
            res_lo = '0;
        end else begin
            res_hi = rem;
            res_lo = quot;
        end
    end

    // Datapath: operand capture, iteration, HI/LO write-back and done pulse
    // NOTE: the working registers are reset too, so an aborted op can never leak
    // stale partial values into a later result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!bus.flush) begin
                case (state_q)
                    IDLE: begin
                        if (bus.start) begin
                            if (is_muldiv) begin
                                acc_q    <= {{WIDTH{1'b0}}, a_abs};
                                opnd_q   <= b_abs;
                                cnt_q    <= '0;
                                is_div_q <= bus.op[1];
                                neg_q    <= a_neg ^ b_neg;
                                rneg_q   <= a_neg;
                                div0_q   <= (bus.b == '0);
                            end else if (is_mthi) begin
                                hi_q   <= bus.a;
                                done_q <= 1'b1;
                            end else if (is_mtlo) begin
                                lo_q   <= bus.a;
                                done_q <= 1'b1;
                            end
                        end
                    end
                    CALC: begin
                        acc_q <= acc_step;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    FIX: begin
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                        done_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: table of mul/div vectors on a 32-bit instance,
// hand sequences for MT ops, busy-start, flush and async reset, plus an 8-bit instance.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(32)) bus32 ();
    muldiv_if #(.WIDTH(8))  bus8 ();

    muldiv_unit #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
    muldiv_unit #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

    localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV = 3'b010,
                           OP_DIVU = 3'b011, OP_MTHI = 3'b100, OP_MTLO = 3'b101,
                           OP_NOP  = 3'b110;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns just after the accepting edge (edge 0).
    task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus32.start = 1'b1;
        bus32.op    = op;
        bus32.a     = a;
        bus32.b     = b;
        step();
        bus32.start = 1'b0;
    endtask

    // Wait (bounded) for done; lat = edges since entry, busy_n = busy samples seen,
    // changed = hi/lo moved before done.
    task automatic wait_done32(output int lat, output int busy_n, output bit changed);
        logic [31:0] hi0, lo0;
        hi0     = bus32.hi;
        lo0     = bus32.lo;
        lat     = -1;
        busy_n  = 0;
        changed = 1'b0;
        for (int k = 0; k <= 100; k++) begin
            if (bus32.done) begin
                lat = k;
                break;
            end
            if (bus32.busy) busy_n++;
            if (bus32.hi !== hi0 || bus32.lo !== lo0) changed = 1'b1;
            step();
        end
    endtask

    vec_t vecs[10];
    int   lat, busy_n;
    bit   changed;

    initial begin
        vecs[0] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[3] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4] = '{OP_DIVU,  32'h00000007, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[5] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
        vecs[7] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8] = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[9] = '{OP_DIV,   32'h00000005, 32'h00000000, 32'h00000000, 32'h00000000};

        rst_n       = 1'b0;
        bus32.start = 1'b0; bus32.op = OP_NOP; bus32.a = '0; bus32.b = '0; bus32.flush = 1'b0;
        bus8.start  = 1'b0; bus8.op  = OP_NOP; bus8.a  = '0; bus8.b  = '0; bus8.flush  = 1'b0;
        #2;
        check("reset busy", bus32.busy, 0);
        check("reset done", bus32.done, 0);
        check("reset hi",   bus32.hi,   0);
        check("reset lo",   bus32.lo,   0);
        #10 rst_n = 1'b1;
        step();

        // Table-driven mul/div vectors
        for (int i = 0; i < 10; i++) begin
            issue32(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done32(lat, busy_n, changed);
            check($sformatf("vec%0d latency", i), lat, 33);
            check($sformatf("vec%0d busy cycles", i), busy_n, 33);
            check($sformatf("vec%0d hi/lo stable in CALC", i), changed, 0);
            check($sformatf("vec%0d busy at done", i), bus32.busy, 0);
            check($sformatf("vec%0d hi", i), bus32.hi, vecs[i].hi);
            check($sformatf("vec%0d lo", i), bus32.lo, vecs[i].lo);
            step();
            check($sformatf("vec%0d done single pulse", i), bus32.done, 0);
        end

        // MTHI then MTLO back to back, then a no-op
        bus32.start = 1'b1; bus32.op = OP_MTHI; bus32.a = 32'h12345678;
        step();
        check("mthi hi", bus32.hi, 32'h12345678);
        check("mthi lo kept", bus32.lo, 32'h00000000);
        check("mthi done", bus32.done, 1);
        check("mthi busy", bus32.busy, 0);
        bus32.op = OP_MTLO; bus32.a = 32'h9ABCDEF0;
        step();
        check("mtlo lo", bus32.lo, 32'h9ABCDEF0);
        check("mtlo hi kept", bus32.hi, 32'h12345678);
        check("mtlo done", bus32.done, 1);
        check("mtlo busy", bus32.busy, 0);
        bus32.op = OP_NOP; bus32.a = 32'hDEADBEEF;
        step();
        bus32.start = 1'b0;
        check("nop done", bus32.done, 0);
        check("nop busy", bus32.busy, 0);
        check("nop hi", bus32.hi, 32'h12345678);
        check("nop lo", bus32.lo, 32'h9ABCDEF0);

        // MULT 6*7 with a DIVU start presented mid-CALC
        issue32(OP_MULT, 32'd6, 32'd7);
        repeat (5) step();
        bus32.start = 1'b1; bus32.op = OP_DIVU; bus32.a = 32'd100; bus32.b = 32'd3;
        step();
        step();
        bus32.start = 1'b0;
        wait_done32(lat, busy_n, changed);
        check("busy-start latency", lat + 7, 33);
        check("busy-start hi", bus32.hi, 32'd0);
        check("busy-start lo", bus32.lo, 32'd42);
        step();

        // Flush part-way through a DIV
        issue32(OP_DIV, 32'd100, 32'd3);
        repeat (9) step();
        bus32.flush = 1'b1;
        step();
        bus32.flush = 1'b0;
        check("flush busy", bus32.busy, 0);
        check("flush done", bus32.done, 0);
        check("flush hi", bus32.hi, 32'd0);
        check("flush lo", bus32.lo, 32'd42);
        repeat (35) begin
            if (bus32.done) break;
            step();
        end
        check("flush no late done", bus32.done, 0);

        // Flush and start in the same idle cycle: request dropped
        bus32.flush = 1'b1;
        issue32(OP_MULT, 32'd2, 32'd3);
        bus32.flush = 1'b0;
        check("flush+start busy", bus32.busy, 0);
        check("flush+start done", bus32.done, 0);

        // Asynchronous reset between edges, mid-CALC
        issue32(OP_MULT, 32'd3, 32'd3);
        repeat (4) step();
        check("pre-reset busy", bus32.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset busy", bus32.busy, 0);
        check("async reset done", bus32.done, 0);
        check("async reset hi", bus32.hi, 0);
        check("async reset lo", bus32.lo, 0);
        #3 rst_n = 1'b1;
        step();

        // 8-bit instance: MULT 0x80*0x80 and DIV overflow
        for (int j = 0; j < 2; j++) begin
            logic [2:0] op8;
            logic [7:0] a8, b8, ehi, elo;
            int         lat8;
            if (j == 0) begin
                op8 = OP_MULT; a8 = 8'h80; b8 = 8'h80; ehi = 8'h40; elo = 8'h00;
            end else begin
                op8 = OP_DIV;  a8 = 8'h80; b8 = 8'hFF; ehi = 8'h00; elo = 8'h80;
            end
            bus8.start = 1'b1; bus8.op = op8; bus8.a = a8; bus8.b = b8;
            step();
            bus8.start = 1'b0;
            lat8 = -1;
            for (int k = 0; k <= 40; k++) begin
                if (bus8.done) begin
                    lat8 = k;
                    break;
                end
                step();
            end
            check($sformatf("w8 vec%0d latency", j), lat8, 9);
            check($sformatf("w8 vec%0d hi", j), bus8.hi, ehi);
            check($sformatf("w8 vec%0d lo", j), bus8.lo, elo);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit owning the architectural HI/LO registers, the multi-cycle successor to the single-cycle ALU mul/div path. It sits beside the ALU in EX: it accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests with a start pulse, signals busy so hazard logic can stall MFHI/MFLO and further mul/div ops, and presents registered hi/lo. It adds unsigned modes, a defined divide-overflow result, a pipeline flush and atomic HI/LO update.

Parameters:
WIDTH, 32, operand width and width of each of hi/lo (must be >= 4)
CNT_W, $clog2(WIDTH), width of the iteration counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request valid; sampled only when busy=0
op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
a  in  WIDTH  operand rs (multiplicand / dividend / MT source)
b  in  WIDTH  operand rt (multiplier / divisor)
flush  in  1  synchronous abort of any in-flight op
busy  out  1  high while state != IDLE
done  out  1  one-cycle pulse the cycle after hi/lo are written by a mul/div or MT op
hi  out  WIDTH  HI register (product upper half / remainder)
lo  out  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, working regs=0. Reset mid-operation discards the op; hi/lo return to 0.
- States: IDLE, CALC, FIX. busy=1 in CALC and FIX.
- IDLE, start=1, op MULT/MULTU/DIV/DIVU: capture |a|,|b| (signed ops) or a,b raw (unsigned), record result sign(s) and op; counter=0; -> CALC.
- IDLE, start=1, op MTHI/MTLO: hi<=a (resp. lo<=a) at that edge; other register unchanged; done=1 next cycle; stay IDLE, busy never asserts.
- IDLE, op 11x or start=0: no state change, done=0.
- CALC: one radix-2 step per cycle (shift-add multiply on 2*WIDTH accumulator; restoring divide, one quotient bit per cycle). After WIDTH steps (counter WIDTH-1) -> FIX.
- FIX: apply sign correction; write hi/lo at the exit edge -> IDLE; done=1 in the following cycle.
- Latency: start sampled at edge 0 -> hi/lo updated and done=1 after edge WIDTH+1 (edge 33 for WIDTH=32); next start accepted in that same done cycle.
- hi/lo change only at FIX exit or MT edge; never partial values during CALC.
- MULT: 2*WIDTH-bit two's-complement product, negated if sign(a)!=sign(b). MULTU: unsigned product.
- DIV: quotient truncates toward zero; remainder takes sign of dividend. DIVU: unsigned.
- Divide by zero (b=0, DIV or DIVU): hi=0, lo=0 (matches existing ALU behaviour); still full latency.
- DIV overflow (a=most-negative, b=-1): lo=a (most-negative), hi=0.
- start while busy=1: ignored, no effect on in-flight op.
- flush=1: any state -> IDLE at next edge, hi/lo unchanged, no done pulse. flush and start in same IDLE cycle: flush wins, request dropped. flush in done cycle does not retract done.
- No combinational path from inputs to outputs.

Test Plan:
- Reset then MULT a=0xFFFFFFFD(-3), b=5 -> busy high 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1, done one cycle exactly after edge 33.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; followed by MULT of same operands -> hi=0, lo=1.
- DIV a=0xFFFFFFF9(-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> hi=lo=0; DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 back-to-back -> hi/lo updated on each edge, busy never high, done pulses twice; start with op=110 -> no change.
- MULT 6*7 started, start with DIVU asserted mid-CALC -> ignored, result hi=0, lo=42; then flush at cycle 10 of a new DIV -> busy low next cycle, hi/lo still 0/42, no done.
- rst_n deasserted asynchronously mid-CALC (between edges) -> busy, done, hi, lo immediately 0; WIDTH=8 instance: MULT 0x80*0x80 -> hi=0x40, lo=0x00 after edge 9.
